// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: zero-register index,
// clear/ready FSM encoding and address-width helper.
package regfile_mp_pkg;

  localparam int R0_IDX = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  function automatic int calc_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register mux, same-cycle write bypass, zero-register and
// not-ready masking for both data and pending bit.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           pend,
  input  logic                      ready,
  input  logic [AW-1:0]             raddr,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic                      alloc,
  input  logic [AW-1:0]             alloc_addr,
  output logic [XLEN-1:0]           rdata,
  output logic                      rpend
);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = ZERO_R0 && (raddr == AW'(R0_IDX));
  assign byp_hit  = BYPASS && we && (waddr == raddr);

  always_comb begin
    rdata = '0;
    rpend = 1'b0;
    if (ready && !zero_hit) begin
      if (byp_hit) begin
        rdata = wdata;
        // post-write pending value: a same-cycle alloc re-marks it
        rpend = alloc && (alloc_addr == raddr);
      end else begin
        rdata = regs[raddr];
        rpend = pend[raddr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised integer register file with bypass, pending scoreboard and a
// sequenced post-reset clear that raises ready when done.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 32,
  parameter  int NRD     = 2,
  parameter  bit BYPASS  = 1'b1,
  parameter  bit ZERO_R0 = 1'b1,
  localparam int AW      = calc_aw(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rpend,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 alloc,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 ready
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           pend;
  rf_state_e                 state;
  logic [AW-1:0]             clr_idx;
  logic                      wr_ok;
  logic                      al_ok;

  assign ready = (state == ST_READY);
  assign wr_ok = we && !(ZERO_R0 && (waddr == AW'(R0_IDX)));
  assign al_ok = alloc && !(ZERO_R0 && (alloc_addr == AW'(R0_IDX)));

  // Storage is not reset directly; the CLEAR walk zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      pend    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          regs[clr_idx] <= '0;
          if (clr_idx == AW'(NREG - 1)) state <= ST_READY;
          else                          clr_idx <= clr_idx + AW'(1);
        end
        default: begin
          if (wr_ok) regs[waddr] <= wdata;
          // alloc assigned last so it wins over a same-register retire
          if (we)    pend[waddr] <= 1'b0;
          if (al_ok) pend[alloc_addr] <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
    ) u_rd (
      .regs       (regs),
      .pend       (pend),
      .ready      (ready),
      .raddr      (raddr[k*AW +: AW]),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .alloc      (alloc),
      .alloc_addr (alloc_addr),
      .rdata      (rdata[k*XLEN +: XLEN]),
      .rpend      (rpend[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance
// share all inputs so both behaviours are observed on the same vectors.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] raddr;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              alloc;
  logic [AW-1:0]     alloc_addr;

  logic [NRD*XLEN-1:0] rdata, rdata_nb;
  logic [NRD-1:0]      rpend, rpend_nb;
  logic                ready, ready_nb;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc(alloc), .alloc_addr(alloc_addr),
    .ready(ready)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rpend(rpend_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .alloc(alloc), .alloc_addr(alloc_addr),
    .ready(ready_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; alloc = 1'b0; alloc_addr = '0;
    set_rd(5'd5, 5'd5);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= NREG; e++) begin
      #1;
      total_cnt++;
      if (ready !== 1'b0 || ready_nb !== 1'b0)
        $display("FAIL reset_ready_low edge%0d: got %b/%b want 0", e, ready, ready_nb);
      else pass_cnt++;
      total_cnt++;
      if (rdata !== '0 || rpend !== '0)
        $display("FAIL reset_rdata_zero edge%0d: got %h/%b want 0", e, rdata, rpend);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (ready !== 1'b1 || ready_nb !== 1'b1)
      $display("FAIL reset_ready_high: got %b/%b want 1", ready, ready_nb);
    else pass_cnt++;
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(AW'(r), AW'(r + 1));
      #1;
      total_cnt++;
      if (rdata !== '0 || rpend !== '0 || rdata_nb !== '0)
        $display("FAIL reset_contents r%0d: got %h/%b want 0", r, rdata, rpend);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_bypass();
    set_rd(5'd7, 5'd7);
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL bypass_same_cycle: got %h want deadbeefdeadbeef", rdata);
    else pass_cnt++;
    total_cnt++;
    if (rdata_nb !== 64'h0)
      $display("FAIL nobypass_old_value: got %h want 0", rdata_nb);
    else pass_cnt++;
    tick();
    we = 1'b0;
    #1;
    total_cnt++;
    if (rdata_nb !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL nobypass_next_cycle: got %h want deadbeefdeadbeef", rdata_nb);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL bypass_stored: got %h want deadbeefdeadbeef", rdata);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    set_rd(5'd0, 5'd0);
    #1;
    total_cnt++;
    if (rdata !== '0 || rpend !== '0)
      $display("FAIL zero_before: got %h/%b want 0", rdata, rpend);
    else pass_cnt++;
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; alloc = 1'b1; alloc_addr = 5'd0;
    #1;
    total_cnt++;
    if (rdata !== '0 || rpend !== '0 || rdata_nb !== '0 || rpend_nb !== '0)
      $display("FAIL zero_during: got %h/%b want 0", rdata, rpend);
    else pass_cnt++;
    tick();
    we = 1'b0; alloc = 1'b0;
    #1;
    total_cnt++;
    if (rdata !== '0 || rpend !== '0 || rdata_nb !== '0 || rpend_nb !== '0)
      $display("FAIL zero_after: got %h/%b nb %h/%b want 0", rdata, rpend, rdata_nb, rpend_nb);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    set_rd(5'd3, 5'd3);
    alloc = 1'b1; alloc_addr = 5'd3;
    #1;
    total_cnt++;
    if (rpend !== 2'b00)
      $display("FAIL sb_alloc_same_cycle: got %b want 00", rpend);
    else pass_cnt++;
    tick();
    alloc = 1'b0;
    #1;
    total_cnt++;
    if (rpend !== 2'b11 || rpend_nb !== 2'b11)
      $display("FAIL sb_alloc_next: got %b/%b want 11", rpend, rpend_nb);
    else pass_cnt++;
    we = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
    #1;
    total_cnt++;
    if (rpend !== 2'b00 || rdata[31:0] !== 32'hA5)
      $display("FAIL sb_write_bypass: got %b/%h want 00/a5", rpend, rdata[31:0]);
    else pass_cnt++;
    total_cnt++;
    if (rpend_nb !== 2'b11)
      $display("FAIL sb_write_nobypass: got %b want 11", rpend_nb);
    else pass_cnt++;
    tick();
    we = 1'b0;
    #1;
    total_cnt++;
    if (rpend !== 2'b00 || rpend_nb !== 2'b00 || rdata_nb[31:0] !== 32'hA5)
      $display("FAIL sb_write_held: got %b/%b/%h want 00/00/a5", rpend, rpend_nb, rdata_nb[31:0]);
    else pass_cnt++;
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000005A; alloc = 1'b1; alloc_addr = 5'd3;
    #1;
    total_cnt++;
    if (rpend !== 2'b11 || rdata !== {32'h5A, 32'h5A})
      $display("FAIL sb_both_same_cycle: got %b/%h want 11/5a", rpend, rdata);
    else pass_cnt++;
    tick();
    we = 1'b0; alloc = 1'b0;
    #1;
    total_cnt++;
    if (rpend !== 2'b11 || rpend_nb !== 2'b11 || rdata_nb !== {32'h5A, 32'h5A})
      $display("FAIL sb_both_after: got %b/%b/%h want 11/11/5a", rpend, rpend_nb, rdata_nb);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    set_rd(5'd9, 5'd3);
    alloc = 1'b1; alloc_addr = 5'd9;
    tick();
    alloc = 1'b0;
    #1;
    total_cnt++;
    if (rpend !== 2'b11)
      $display("FAIL midclr_pre_pend: got %b want 11", rpend);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= NREG; e++) begin
      #1;
      total_cnt++;
      if (ready !== 1'b0)
        $display("FAIL midclr_ready_low edge%0d: got %b want 0", e, ready);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (ready !== 1'b1)
      $display("FAIL midclr_ready_high: got %b want 1", ready);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (rpend !== 2'b00 || rpend_nb !== 2'b00 || rdata !== '0)
      $display("FAIL midclr_pend_cleared: got %b/%b/%h want 00/00/0", rpend, rpend_nb, rdata);
    else pass_cnt++;
  endtask

  task automatic test_ignored_during_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'hFF; alloc = 1'b1; alloc_addr = 5'd4;
    repeat (NREG) tick();
    we = 1'b0; alloc = 1'b0;
    set_rd(5'd4, 5'd4);
    #1;
    total_cnt++;
    if (ready !== 1'b1)
      $display("FAIL ign_ready: got %b want 1", ready);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== '0 || rpend !== '0 || rdata_nb !== '0 || rpend_nb !== '0)
      $display("FAIL ign_reg4: got %h/%b nb %h/%b want 0", rdata, rpend, rdata_nb, rpend_nb);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid_clear();
    test_ignored_during_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
